bcd_entry_loader: RTL and testbench
===================================

# bcd_entry_loader

Upstream front end for the four-number sorter. It lets the user key in four BCD digits one at a time using four switches and an ENTER button, holding each digit in its own slot. When all four slots are full it drives them on the sorter's A–D inputs and raises a level GO that stands in for the sorter's start button. GO stays high, holding the sorted display, until the user presses CLEAR.

## Interface
Parameters:
- DB_CYCLES, default 1000000: number of consecutive stable samples needed to accept a button level (about 10 ms at 100 MHz).

Ports:
- CLK, input, 1: system clock (100 MHz).
- RST_N, input, 1: reset; asynchronous, active-low.
- SW, input, 4: digit value presented on the switches; treated as quasi-static and not synchronised.
- BTN_ENT, input, 1: raw ENTER pushbutton, active-high, asynchronous.
- BTN_CLR, input, 1: raw CLEAR pushbutton, active-high, asynchronous.
- A, B, C, D, output, 4 each: slots 0–3; feed the sorter's A–D inputs.
- GO, output, 1: all four slots loaded; drives the sorter's BTN input.
- IDX, output, 2: index of the next slot to fill; 0 when FULL.
- ERR, output, 1: the last ENTER was rejected because it was a non-BCD value.

## Operation
- Each button passes through its own debouncer: 2-FF synchroniser, then a stability counter. The debounced level changes only after DB_CYCLES consecutive samples disagree with the current level. A rising edge of the debounced level produces a one-cycle press pulse.
- FSM states:
  - ENTRY: IDX selects the target slot.
  - FULL: all four slots are loaded.
- ENTRY, enter pulse with SW ≤ 9: slot[IDX] ← SW, ERR ← 0.
  - If IDX = 3: go to FULL, GO ← 1, IDX ← 0.
  - Otherwise: IDX ← IDX + 1.
- ENTRY, enter pulse with SW ≥ 10: no slot write, IDX unchanged, ERR ← 1.
- FULL: enter pulses are ignored; A–D and GO hold.
- Clear pulse, in any state: all slots ← 0, IDX ← 0, ERR ← 0, GO ← 0, state ← ENTRY.
- Clear and enter pulses in the same cycle: clear wins and the enter is discarded.
- Holding a button produces exactly one pulse; release produces no pulse.
- Bounces shorter than DB_CYCLES produce no pulse.

## Timing
- Reset (RST_N low) forces, asynchronously:
  - outputs A–D = 0, GO = 0, IDX = 0, ERR = 0, state ENTRY;
  - synchronisers and debounced levels = 0, debounce counters = 0.
- RST_N low mid-entry or while FULL discards all loaded digits. The first press after release needs the full debounce interval.
- Latency from a raw edge that stays stable to the press pulse: 2 synchroniser cycles plus DB_CYCLES cycles. Slot, IDX, ERR and GO update on the clock edge after the pulse, so the total is DB_CYCLES + 3 edges.
- GO is a registered level. It stays high for as long as FULL lasts, so a sorter running on a slow (~2 Hz) clock always samples it.
- A–D change only on a successful entry or a clear. While GO = 1 they are stable, as the sorter requires.
- The debounce counter saturates and cannot wrap. It is sized to clog2(DB_CYCLES + 1) bits.

## Structure
- Shared header sort_defs.vh holds:
  - BCD_MAX = 4'd9;
  - the FSM state encodings ST_ENTRY and ST_FULL;
  - the digit width of 4.
- Sub-module debounce_pulse (parameter DB_CYCLES; ports CLK, RST_N, raw, level, pulse), instantiated twice.
- Top-level loader: FSM, IDX counter, four 4-bit slot registers, ERR and GO registers.

## Test plan
All scenarios run with DB_CYCLES = 4.
- Reset: RST_N low for 3 cycles → A–D = 0, GO = 0, IDX = 0, ERR = 0. Releasing RST_N with a button already held high yields one pulse after 6 cycles.
- Enter SW = 7, 2, 9, 0 with clean presses → A=7, B=2, C=9, D=0. IDX steps 1, 2, 3, 0. GO rises on the edge after the fourth pulse and stays high for 1000 cycles.
- Bounce: BTN_ENT toggles every 2 cycles for 20 cycles, then stays high → exactly one slot write and one IDX increment.
- Non-BCD entry: SW = 12, ENTER → ERR = 1, IDX unchanged, slot unchanged. Then SW = 5, ENTER → ERR = 0 and the slot holds 5.
- While FULL: ENTER with SW = 3 → no change. CLEAR → A–D = 0, GO = 0, IDX = 0 on the edge after the clear pulse.
- BTN_CLR and BTN_ENT rise together during ENTRY with IDX = 2 → clear takes effect and no slot is written. Then assert RST_N low mid-debounce → no pulse is generated and all outputs are 0.

Source files
------------

// File: rtl/bcd_entry_loader_pkg.sv
// Shared definitions for the BCD entry loader: digit width, BCD limit, FSM encodings.
package bcd_entry_loader_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_entry_loader_debounce_pulse.sv
// Button conditioner: 2-FF synchroniser, saturating stability counter, rising-edge press pulse.
// Pulse appears DB_CYCLES + 2 cycles after a raw edge that stays stable; no backpressure.
module debounce_pulse #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flip;

    // The DB_CYCLES-th disagreeing sample flips the level; the counter restarts so it never wraps.
    assign w_flip = (r_sync1 != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= raw;
            r_sync1 <= r_sync0;
            r_pulse <= w_flip && r_sync1;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule

// File: rtl/bcd_entry_loader.sv
// Keys four BCD digits into slots A-D via debounced ENTER/CLEAR buttons, then raises GO.
// Slot/IDX/ERR/GO update one cycle after the press pulse; GO holds until CLEAR.
module bcd_entry_loader
    import bcd_entry_loader_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [DIGIT_W-1:0] SW,
    input  logic               BTN_ENT,
    input  logic               BTN_CLR,
    output logic [DIGIT_W-1:0] A,
    output logic [DIGIT_W-1:0] B,
    output logic [DIGIT_W-1:0] C,
    output logic [DIGIT_W-1:0] D,
    output logic               GO,
    output logic [1:0]         IDX,
    output logic               ERR
);

    logic w_ent_pulse;
    logic w_clr_pulse;
    logic w_unused_ent_level;
    logic w_unused_clr_level;

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_ent (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (BTN_ENT),
        .level (w_unused_ent_level),
        .pulse (w_ent_pulse)
    );

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (BTN_CLR),
        .level (w_unused_clr_level),
        .pulse (w_clr_pulse)
    );

    state_t                       r_state;
    logic [1:0]                   r_idx;
    logic                         r_err;
    logic                         r_go;
    logic [3:0][DIGIT_W-1:0]      r_slot;

    state_t                       w_state_nxt;
    logic [1:0]                   w_idx_nxt;
    logic                         w_err_nxt;
    logic                         w_go_nxt;
    logic [3:0][DIGIT_W-1:0]      w_slot_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_ENTRY;
            r_idx   <= 2'd0;
            r_err   <= 1'b0;
            r_go    <= 1'b0;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
            r_go    <= w_go_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    // Clear has priority, so a simultaneous enter is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_go_nxt    = r_go;
        w_slot_nxt  = r_slot;
        if (w_clr_pulse) begin
            w_state_nxt = ST_ENTRY;
            w_idx_nxt   = 2'd0;
            w_err_nxt   = 1'b0;
            w_go_nxt    = 1'b0;
            w_slot_nxt  = '0;
        end else if (w_ent_pulse && (r_state == ST_ENTRY)) begin
            if (is_bcd(SW)) begin
                w_slot_nxt[r_idx] = SW;
                w_err_nxt         = 1'b0;
                if (r_idx == 2'd3) begin
                    w_state_nxt = ST_FULL;
                    w_go_nxt    = 1'b1;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end else begin
                w_err_nxt = 1'b1;
            end
        end
    end

    assign A   = r_slot[0];
    assign B   = r_slot[1];
    assign C   = r_slot[2];
    assign D   = r_slot[3];
    assign GO  = r_go;
    assign IDX = r_idx;
    assign ERR = r_err;

endmodule

// File: tb/tb_bcd_entry_loader.sv
// Directed bench for bcd_entry_loader with DB_CYCLES = 4 and a queue of expected output snapshots.
module tb_bcd_entry_loader;

    localparam int DB = 4;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic       go;
        logic [1:0] idx;
        logic       err;
    } snap_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] SW = 4'd0;
    logic       BTN_ENT = 1'b0;
    logic       BTN_CLR = 1'b0;
    logic [3:0] A, B, C, D;
    logic       GO;
    logic [1:0] IDX;
    logic       ERR;

    int vectors = 0;
    int miscompares = 0;

    snap_t exp_q[$];

    logic [3:0] m_slot [4];
    logic [1:0] m_idx;
    logic       m_err;
    logic       m_go;
    logic       m_full;

    bcd_entry_loader #(.DB_CYCLES(DB)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SW      (SW),
        .BTN_ENT (BTN_ENT),
        .BTN_CLR (BTN_CLR),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .GO      (GO),
        .IDX     (IDX),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_slot[i] = 4'd0;
        m_idx = 2'd0; m_err = 1'b0; m_go = 1'b0; m_full = 1'b0;
    endtask

    task automatic model_apply(input logic ent, input logic clr, input logic [3:0] sw);
        if (clr) begin
            model_clear();
        end else if (ent && !m_full) begin
            if (sw <= 4'd9) begin
                m_slot[m_idx] = sw;
                m_err = 1'b0;
                if (m_idx == 2'd3) begin
                    m_full = 1'b1; m_go = 1'b1; m_idx = 2'd0;
                end else begin
                    m_idx = m_idx + 2'd1;
                end
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic push_exp();
        snap_t s;
        s = '{a: m_slot[0], b: m_slot[1], c: m_slot[2], d: m_slot[3],
              go: m_go, idx: m_idx, err: m_err};
        exp_q.push_back(s);
    endtask

    task automatic check(input string tag);
        snap_t obs;
        snap_t exp;
        obs = '{a: A, b: B, c: C, d: D, go: GO, idx: IDX, err: ERR};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Clean press: hold long enough for the update, release and let the level settle low.
    task automatic press(input logic ent, input logic clr, input logic [3:0] sw, input string tag);
        SW = sw; BTN_ENT = ent; BTN_CLR = clr;
        model_apply(ent, clr, sw);
        push_exp();
        cycles(DB + 5);
        check(tag);
        BTN_ENT = 1'b0; BTN_CLR = 1'b0;
        cycles(DB + 6);
    endtask

    initial begin
        model_clear();

        // Reset held with ENTER already pressed
        @(negedge CLK);
        RST_N = 1'b0; BTN_ENT = 1'b1; SW = 4'd7;
        cycles(3);
        push_exp(); check("reset_state");
        RST_N = 1'b1;
        cycles(DB + 2);
        push_exp(); check("held_before_pulse");
        cycles(1);
        model_apply(1'b1, 1'b0, 4'd7);
        push_exp(); check("held_after_pulse");
        cycles(DB + 10);
        push_exp(); check("held_one_pulse");
        BTN_ENT = 1'b0;
        cycles(DB + 6);

        press(1'b1, 1'b0, 4'd2, "enter_2");
        press(1'b1, 1'b0, 4'd9, "enter_9");
        press(1'b1, 1'b0, 4'd0, "enter_0_go");

        for (int k = 0; k < 10; k++) begin
            cycles(100);
            push_exp(); check("go_hold");
        end

        press(1'b1, 1'b0, 4'd3, "full_enter_ignored");

        // Clear with exact latency: unchanged after 6 edges, cleared on the 7th
        BTN_CLR = 1'b1;
        cycles(DB + 2);
        push_exp(); check("clear_before_pulse");
        cycles(1);
        model_apply(1'b0, 1'b1, 4'd0);
        push_exp(); check("clear_after_pulse");
        BTN_CLR = 1'b0;
        cycles(DB + 6);

        // Bouncing ENTER: toggles every 2 cycles, then held high
        SW = 4'd4;
        for (int t = 0; t < 10; t++) begin
            BTN_ENT = ~BTN_ENT;
            cycles(2);
        end
        push_exp(); check("bounce_no_pulse");
        BTN_ENT = 1'b1;
        model_apply(1'b1, 1'b0, 4'd4);
        cycles(DB + 5);
        push_exp(); check("bounce_one_write");
        cycles(20);
        push_exp(); check("bounce_still_one");
        BTN_ENT = 1'b0;
        cycles(DB + 6);

        press(1'b1, 1'b0, 4'd12, "non_bcd_err");
        press(1'b1, 1'b0, 4'd5,  "bcd_after_err");

        press(1'b1, 1'b1, 4'd8, "clear_beats_enter");

        press(1'b1, 1'b0, 4'd6, "enter_before_rst");

        // Reset in the middle of a debounce
        SW = 4'd1; BTN_ENT = 1'b1;
        cycles(3);
        RST_N = 1'b0;
        model_clear();
        cycles(2);
        push_exp(); check("mid_debounce_reset");
        BTN_ENT = 1'b0;
        cycles(1);
        RST_N = 1'b1;
        cycles(DB + 10);
        push_exp(); check("no_pulse_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
